// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, stage-control bundle and canned control patterns
// for the LEGv8 five-stage pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    MEMWAIT,
    DRAIN,
    HALTED
  } pctl_state_t;

  // Drain counter width; supports up to 16 drain cycles.
  localparam int DRAIN_W = 4;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0,
    idex_flush: 1'b0, exmem_en: 1'b0, exmem_flush: 1'b0, memwb_en: 1'b0
  };

  localparam pipe_ctl_t CTL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  // Taken branch squashes the three younger instructions behind MEM.
  localparam pipe_ctl_t CTL_BRANCH = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
    idex_flush: 1'b1, exmem_en: 1'b1, exmem_flush: 1'b1, memwb_en: 1'b1
  };

  localparam pipe_ctl_t CTL_LOAD_USE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b1, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  localparam pipe_ctl_t CTL_HALT = '{
    pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  localparam pipe_ctl_t CTL_DRAIN = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b1, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  // Once in MEMWAIT the request is known to be pending, so only ready matters.
  function automatic logic mem_blocked(input pctl_state_t st, input logic req,
                                       input logic rdy);
    return (st == MEMWAIT) ? !rdy : (req && !rdy);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Holds at all-ones instead of wrapping so overflowed counts stay obvious.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage LEGv8 pipeline: turns hazard, branch,
// memory-wait and halt inputs into per-stage enable/flush controls.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             ld_stall,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  pctl_state_t        r_state;
  logic [DRAIN_W-1:0] r_drain;

  pctl_state_t        w_next_state;
  logic [DRAIN_W-1:0] w_next_drain;
  pipe_ctl_t          w_ctl;
  logic               w_stall_inc;
  logic               w_flush_inc;

  // Mealy control decode; the RUN priority chain is shared by the MEMWAIT
  // release cycle because the held inputs are still valid then.
  always_comb begin
    w_ctl        = CTL_FREEZE;
    w_next_state = r_state;
    w_next_drain = r_drain;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
        end
      end
      RUN, MEMWAIT: begin
        if (mem_blocked(r_state, dmem_req, dmem_ready)) begin
          w_stall_inc  = 1'b1;
          w_next_state = MEMWAIT;
        end else if (br_taken) begin
          w_ctl        = CTL_BRANCH;
          w_flush_inc  = 1'b1;
          w_next_state = RUN;
        end else if (ld_stall) begin
          w_ctl        = CTL_LOAD_USE;
          w_stall_inc  = 1'b1;
          w_next_state = RUN;
        end else if (halt_req) begin
          w_ctl        = CTL_HALT;
          w_next_drain = DRAIN_LOAD;
          w_next_state = DRAIN;
        end else begin
          w_ctl        = CTL_ADVANCE;
          w_next_state = RUN;
        end
      end
      DRAIN: begin
        if (mem_blocked(r_state, dmem_req, dmem_ready)) begin
          w_stall_inc = 1'b1;
        end else begin
          w_ctl = CTL_DRAIN;
          if (r_drain == '0) begin
            w_next_state = HALTED;
          end else begin
            w_next_drain = r_drain - DRAIN_W'(1);
          end
        end
      end
      HALTED: begin
        w_ctl = CTL_FREEZE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_drain <= '0;
    end else begin
      r_state <= w_next_state;
      r_drain <= w_next_drain;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_stall_inc),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_flush_inc),
    .o_count (flush_cnt)
  );

  assign pc_en       = w_ctl.pc_en;
  assign ifid_en     = w_ctl.ifid_en;
  assign ifid_flush  = w_ctl.ifid_flush;
  assign idex_en     = w_ctl.idex_en;
  assign idex_flush  = w_ctl.idex_flush;
  assign exmem_en    = w_ctl.exmem_en;
  assign exmem_flush = w_ctl.exmem_flush;
  assign memwb_en    = w_ctl.memwb_en;
  assign halted      = (r_state == HALTED);

  // A halted core must never advance any pipeline register.
  a_halted_frozen: assert property (@(posedge clk) disable iff (!reset_n)
    halted |-> !(pc_en || ifid_en || idex_en || exmem_en || memwb_en));

  a_drain_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == DRAIN) |-> (r_drain <= DRAIN_LOAD));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vectors, a behavioural
// model checked every cycle, and hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int DRAIN_N = 3;

  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_START = 6'b100000;
  localparam logic [5:0] S_LD    = 6'b010000;
  localparam logic [5:0] S_BR    = 6'b001000;
  localparam logic [5:0] S_HALT  = 6'b000100;
  localparam logic [5:0] S_REQ   = 6'b000010;
  localparam logic [5:0] S_RDY   = 6'b000001;

  // Control patterns ordered {pc, ifid_en, ifid_flush, idex_en, idex_flush,
  // exmem_en, exmem_flush, memwb_en}.
  localparam int P_FREEZE = 'b00000000;
  localparam int P_RUN    = 'b11010101;
  localparam int P_BRANCH = 'b11111111;
  localparam int P_LOAD   = 'b00011101;
  localparam int P_HALT   = 'b01110101;
  localparam int P_DRAIN  = 'b00011101;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start, ldStall, brTaken, haltReq, dmemReq, dmemReady;

  logic pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, exmemFlush, memwbEn, haltedOut;
  logic [15:0] stallCnt, flushCnt;
  logic pcEn4, ifidEn4, ifidFlush4, idexEn4, idexFlush4, exmemEn4, exmemFlush4, memwbEn4, haltedOut4;
  logic [3:0] stallCnt4, flushCnt4;
  logic [7:0] ctl16, ctl4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ld_stall(ldStall),
    .br_taken(brTaken), .halt_req(haltReq), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_en(pcEn), .ifid_en(ifidEn), .ifid_flush(ifidFlush), .idex_en(idexEn),
    .idex_flush(idexFlush), .exmem_en(exmemEn), .exmem_flush(exmemFlush),
    .memwb_en(memwbEn), .halted(haltedOut), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  pipeline_ctrl #(.CNT_W(4), .DRAIN_CYCLES(DRAIN_N)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .ld_stall(ldStall),
    .br_taken(brTaken), .halt_req(haltReq), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_en(pcEn4), .ifid_en(ifidEn4), .ifid_flush(ifidFlush4), .idex_en(idexEn4),
    .idex_flush(idexFlush4), .exmem_en(exmemEn4), .exmem_flush(exmemFlush4),
    .memwb_en(memwbEn4), .halted(haltedOut4), .stall_cnt(stallCnt4), .flush_cnt(flushCnt4)
  );

  assign ctl16 = {pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, exmemFlush, memwbEn};
  assign ctl4  = {pcEn4, ifidEn4, ifidFlush4, idexEn4, idexFlush4, exmemEn4, exmemFlush4, memwbEn4};

  // Behavioural model: started/waiting/halted flags plus remaining drain cycles.
  bit mStarted = 1'b0, mWaiting = 1'b0, mHalted = 1'b0;
  int mDrainLeft = 0, mStall = 0, mFlush = 0;
  bit nStarted = 1'b0, nWaiting = 1'b0, nHalted = 1'b0;
  int nDrainLeft = 0, nStall = 0, nFlush = 0;
  int eCtl = 0;
  int eHalted = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satv(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic void modelStep();
    int pat = P_FREEZE;
    bit memBlock;
    nStarted = mStarted; nWaiting = mWaiting; nHalted = mHalted;
    nDrainLeft = mDrainLeft; nStall = mStall; nFlush = mFlush;
    if (mHalted) begin
      pat = P_FREEZE;
    end else if (!mStarted) begin
      nStarted = start;
    end else if (mDrainLeft > 0) begin
      if (dmemReq && !dmemReady) begin
        nStall = mStall + 1;
      end else begin
        pat = P_DRAIN;
        nDrainLeft = mDrainLeft - 1;
        nHalted = (nDrainLeft == 0);
      end
    end else begin
      memBlock = mWaiting ? !dmemReady : (dmemReq && !dmemReady);
      nWaiting = memBlock;
      if (memBlock) nStall = mStall + 1;
      else if (brTaken) begin pat = P_BRANCH; nFlush = mFlush + 1; end
      else if (ldStall) begin pat = P_LOAD; nStall = mStall + 1; end
      else if (haltReq) begin pat = P_HALT; nDrainLeft = DRAIN_N; end
      else pat = P_RUN;
    end
    eCtl = pat;
    eHalted = mHalted ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst_ctl16", 32'(ctl16), P_FREEZE);
      checkOutput("rst_ctl4", 32'(ctl4), P_FREEZE);
      checkOutput("rst_stall16", 32'(stallCnt), 0);
      checkOutput("rst_flush4", 32'(flushCnt4), 0);
    end else begin
      modelStep();
      checkOutput("model_ctl16", 32'(ctl16), eCtl);
      checkOutput("model_ctl4", 32'(ctl4), eCtl);
      checkOutput("model_halted16", 32'(haltedOut), eHalted);
      checkOutput("model_halted4", 32'(haltedOut4), eHalted);
      checkOutput("model_stall16", 32'(stallCnt), satv(mStall, 65535));
      checkOutput("model_flush16", 32'(flushCnt), satv(mFlush, 65535));
      checkOutput("model_stall4", 32'(stallCnt4), satv(mStall, 15));
      checkOutput("model_flush4", 32'(flushCnt4), satv(mFlush, 15));
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mStarted <= 1'b0; mWaiting <= 1'b0; mHalted <= 1'b0;
      mDrainLeft <= 0; mStall <= 0; mFlush <= 0;
    end else begin
      mStarted <= nStarted; mWaiting <= nWaiting; mHalted <= nHalted;
      mDrainLeft <= nDrainLeft; mStall <= nStall; mFlush <= nFlush;
    end
  end

  task automatic applyStimulus(input logic [5:0] v);
    @(posedge clk);
    #1;
    {start, ldStall, brTaken, haltReq, dmemReq, dmemReady} = v;
  endtask

  // Drive one cycle of inputs, then settle at the falling edge for checks.
  task automatic step(input logic [5:0] v);
    applyStimulus(v);
    @(negedge clk);
  endtask

  initial begin
    {start, ldStall, brTaken, haltReq, dmemReq, dmemReady} = S_NONE;
    repeat (2) @(negedge clk);
    checkOutput("reset_ctl", 32'(ctl16), P_FREEZE);
    checkOutput("reset_halted", 32'(haltedOut), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(S_START);
    checkOutput("idle_start_ctl", 32'(ctl16), P_FREEZE);
    repeat (10) step(S_NONE);
    checkOutput("run_ctl", 32'(ctl16), P_RUN);
    checkOutput("run_stall", 32'(stallCnt), 0);
    checkOutput("run_flush", 32'(flushCnt), 0);

    step(S_LD);
    checkOutput("ldstall_ctl", 32'(ctl16), P_LOAD);
    step(S_NONE);
    checkOutput("ldstall_cnt", 32'(stallCnt), 1);

    step(S_BR | S_LD | S_HALT);
    checkOutput("branch_ctl", 32'(ctl16), P_BRANCH);
    step(S_NONE);
    checkOutput("branch_flush_cnt", 32'(flushCnt), 1);
    checkOutput("branch_stall_cnt", 32'(stallCnt), 1);
    checkOutput("branch_stays_run", 32'(ctl16), P_RUN);

    for (int i = 0; i < 4; i++) begin
      step(S_REQ);
      checkOutput("memwait_ctl", 32'(ctl16), P_FREEZE);
    end
    step(S_REQ | S_RDY);
    checkOutput("memready_ctl", 32'(ctl16), P_RUN);
    checkOutput("memwait_stall", 32'(stallCnt), 5);

    step(S_HALT);
    checkOutput("halt_ctl", 32'(ctl16), P_HALT);
    step(S_NONE);
    checkOutput("drain1_ctl", 32'(ctl16), P_DRAIN);
    step(S_REQ);
    checkOutput("drain_freeze_ctl", 32'(ctl16), P_FREEZE);
    step(S_BR | S_LD);
    checkOutput("drain2_ctl", 32'(ctl16), P_DRAIN);
    checkOutput("drain_freeze_stall", 32'(stallCnt), 6);
    step(S_NONE);
    checkOutput("drain3_ctl", 32'(ctl16), P_DRAIN);
    checkOutput("drain3_not_halted", 32'(haltedOut), 0);
    for (int i = 0; i < 3; i++) begin
      step(S_START);
      checkOutput("halted_flag", 32'(haltedOut), 1);
      checkOutput("halted_ctl", 32'(ctl16), P_FREEZE);
    end

    applyStimulus(S_NONE);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_from_halt", 32'(haltedOut), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    step(S_START);
    for (int i = 0; i < 20; i++) step(S_LD);
    step(S_HALT);
    checkOutput("sat_stall16", 32'(stallCnt), 20);
    checkOutput("sat_stall4", 32'(stallCnt4), 15);
    step(S_NONE);
    checkOutput("pre_rst_drain_ctl", 32'(ctl16), P_DRAIN);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_ctl", 32'(ctl16), P_FREEZE);
    checkOutput("async_rst_stall16", 32'(stallCnt), 0);
    checkOutput("async_rst_stall4", 32'(stallCnt4), 0);
    checkOutput("async_rst_halted", 32'(haltedOut), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(S_START);
    checkOutput("post_rst_idle_ctl", 32'(ctl16), P_FREEZE);
    step(S_NONE);
    checkOutput("post_rst_run_ctl", 32'(ctl16), P_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
